// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache refill arbiter for the single memory port; define MEM_ARB_RR_EN for round-robin
module mem_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    // Owner of the transaction in flight: 1 = D side, 0 = I side.
    logic r_gnt_d;

    logic              r_i_ready;
    logic [DATA_W-1:0] r_i_rdata;
    logic              r_d_ready;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

`ifdef MEM_ARB_RR_EN
    // Side favoured on the next contested grant: 0 = I, 1 = D.
    logic r_rr_d;
`else
    localparam int                CNT_W = 4;
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

    // Consecutive D grants issued while I was waiting.
    logic [CNT_W-1:0] r_starve_cnt;
`endif

    // A simultaneous read+write from the D side is handled as a write.
    assign w_d_req = d_read | d_write;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and grant decision; requests only matter in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_read && w_d_req) begin
`ifdef MEM_ARB_RR_EN
                    if (r_rr_d) begin
                        w_grant_d = 1'b1;
                    end else begin
                        w_grant_i = 1'b1;
                    end
`else
                    if (r_starve_cnt == LIMIT) begin
                        w_grant_i = 1'b1;
                    end else begin
                        w_grant_d = 1'b1;
                    end
`endif
                end else if (i_read) begin
                    w_grant_i = 1'b1;
                end else if (w_d_req) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i || w_grant_d) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_RR_EN
    // Pointer flips on every grant, contested or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_d <= 1'b0;
        end else if (w_grant_i || w_grant_d) begin
            r_rr_d <= ~r_rr_d;
        end
    end
`else
    // Starvation guard: count D grants that bypass a waiting I request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && i_read) begin
            if (r_starve_cnt != LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else if (w_grant_i || w_grant_d) begin
            r_starve_cnt <= '0;
        end
    end
`endif

    // Memory-side registers: loaded at grant, frozen while BUSY, strobes dropped on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_d     <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_grant_i) begin
            r_gnt_d     <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_addr  <= i_addr;
            r_mem_wdata <= '0;
        end else if (w_grant_d) begin
            r_gnt_d     <= 1'b1;
            r_mem_read  <= ~d_write;
            r_mem_write <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_write ? d_wdata : '0;
        end else if ((r_state == ST_BUSY) && mem_ready) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // Requester-side return path: only the owning side's ready/rdata ever move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_ready <= 1'b0;
            r_i_rdata <= '0;
            r_d_ready <= 1'b0;
            r_d_rdata <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            if ((r_state == ST_BUSY) && mem_ready) begin
                if (r_gnt_d) begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_i_ready <= 1'b1;
                    r_i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign i_ready   = r_i_ready;
    assign i_rdata   = r_i_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int SL = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic          i_ready;
    logic [DW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers any strobe after mem_lat cycles with a one-cycle mem_ready.
    int            mem_lat = 3;
    bit            mem_auto = 1'b1;
    int            mem_cnt = 0;
    logic [DW-1:0] mem_line = '0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_auto) begin
                if (rst) begin
                    mem_ready = 1'b0;
                    mem_cnt   = 0;
                end else if (mem_ready) begin
                    mem_ready = 1'b0;
                    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                    mem_cnt   = 0;
                end else if (mem_read || mem_write) begin
                    mem_cnt++;
                    if (mem_cnt >= mem_lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_line;
                    end
                end
            end
        end
    end

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        while (!(mem_read || mem_write) && n < 60) begin
            tick();
            n++;
        end
        chk_b({name, "_strobe_seen"}, mem_read || mem_write, 1'b1);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(i_ready || d_ready) && n < 60) begin
            tick();
            n++;
        end
        chk_b({name, "_ready_seen"}, i_ready || d_ready, 1'b1);
    endtask

    task automatic clear_reqs();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    typedef struct {
        bit            rq_i;
        bit            rq_dr;
        bit            rq_dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;
        logic [DW-1:0] ret;
        int            lat;
        bit            exp_i;
        bit            exp_rd;
        bit            exp_wr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    // Reference model state for the randomized run.
    int            m_starve;
    bit            m_rr_d;
    bit            m_busy;
    bit            m_gnt_i;
    bit            m_ign;
    bit            m_rd;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_i_rdata;
    logic [DW-1:0] m_d_rdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] line_a;
        logic [DW-1:0] line_b;
        logic [DW-1:0] line_c;
        bit            held;
        int            pulses;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0, 128'h0,
                    128'hDEADBEEF_00000000_00000000_00000001, 5, 1'b1, 1'b1, 1'b0, 28'h0000010};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 28'h0, 28'h0ABCDEF,
                    128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 128'hA5A5, 3, 1'b0, 1'b0, 1'b1, 28'h0ABCDEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 28'h0, 28'h0000123, 128'h0,
                    128'hCAFEF00D_11112222_33334444_55556666, 1, 1'b0, 1'b1, 1'b0, 28'h0000123};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0, 28'h0000456,
                    128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000, 128'h77, 2, 1'b0, 1'b0, 1'b1, 28'h0000456};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'h0000077, 28'h0000088, 128'h0,
                    128'h01020304_05060708_090A0B0C_0D0E0F10, 2, RR, 1'b1, 1'b0, RR ? 28'h0000077 : 28'h0000088};

        rst = 1'b1;
        clear_reqs();
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;
        tick();
        chk_b("rst_i_ready", i_ready, 1'b0);
        chk_b("rst_d_ready", d_ready, 1'b0);
        chk_b("rst_mem_read", mem_read, 1'b0);
        chk_b("rst_mem_write", mem_write, 1'b0);
        chk_a("rst_mem_addr", mem_addr, '0);
        chk_d("rst_mem_wdata", mem_wdata, '0);
        chk_d("rst_i_rdata", i_rdata, '0);
        chk_d("rst_d_rdata", d_rdata, '0);
        rst = 1'b0;
        tick();

        // Table-driven single transactions from a freshly reset arbiter.
        for (int k = 0; k < 5; k++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            tick();
            i_read   = vecs[k].rq_i;
            i_addr   = vecs[k].ia;
            d_read   = vecs[k].rq_dr;
            d_write  = vecs[k].rq_dw;
            d_addr   = vecs[k].da;
            d_wdata  = vecs[k].wd;
            mem_line = vecs[k].ret;
            mem_lat  = vecs[k].lat;
            tick();
            chk_b($sformatf("v%0d_mem_read", k), mem_read, vecs[k].exp_rd);
            chk_b($sformatf("v%0d_mem_write", k), mem_write, vecs[k].exp_wr);
            chk_a($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].exp_addr);
            if (vecs[k].exp_wr) begin
                chk_d($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].wd);
            end
            held = 1'b1;
            for (int n = 0; n < 60 && !(i_ready || d_ready); n++) begin
                if (mem_read !== vecs[k].exp_rd || mem_write !== vecs[k].exp_wr ||
                    mem_addr !== vecs[k].exp_addr) begin
                    held = 1'b0;
                end
                tick();
            end
            chk_b($sformatf("v%0d_strobe_held", k), held, 1'b1);
            chk_b($sformatf("v%0d_i_ready", k), i_ready, vecs[k].exp_i);
            chk_b($sformatf("v%0d_d_ready", k), d_ready, !vecs[k].exp_i);
            chk_d($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].exp_i ? vecs[k].ret : '0);
            chk_d($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].exp_i ? '0 : vecs[k].ret);
            chk_b($sformatf("v%0d_strobe_drop", k), mem_read || mem_write, 1'b0);
            clear_reqs();
            tick();
            chk_b($sformatf("v%0d_pulse_end", k), i_ready || d_ready, 1'b0);
            tick();
            tick();
            chk_b($sformatf("v%0d_no_new_txn", k), mem_read || mem_write, 1'b0);
        end

        // Continuous contention: grant order D,D,D,D,I,D (fixed) or I,D,I,D (round-robin).
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_lat = 2;
        i_read  = 1'b1;
        i_addr  = 28'h0000100;
        d_read  = 1'b1;
        d_addr  = 28'h0000200;
        for (int g = 0; g < 6; g++) begin
            bit exp_i;
            exp_i = RR ? (g % 2 == 0) : (g % (SL + 1) == SL);
            wait_strobe($sformatf("sv_g%0d", g));
            chk_a($sformatf("sv_g%0d_addr", g), mem_addr, exp_i ? 28'h0000100 : 28'h0000200);
            wait_ready($sformatf("sv_g%0d", g));
            chk_b($sformatf("sv_g%0d_i_ready", g), i_ready, exp_i);
            if (d_ready) begin
                d_read = 1'b0;
                tick();
                d_read = 1'b1;
            end
        end
        clear_reqs();
        tick();
        tick();
        tick();

        // Reset two cycles into the memory wait.
        line_a   = 128'h0BAD0BAD_0BAD0BAD_0BAD0BAD_0BAD0BAD;
        mem_line = line_a;
        mem_lat  = 5;
        i_read   = 1'b1;
        i_addr   = 28'h0000010;
        tick();
        chk_b("rb_grant", mem_read, 1'b1);
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk_b("rb_async_mem_read", mem_read, 1'b0);
        chk_b("rb_no_i_ready", i_ready, 1'b0);
        i_read = 1'b0;
        tick();
        chk_b("rb_no_i_ready2", i_ready, 1'b0);
        tick();
        rst = 1'b0;
        chk_d("rb_i_rdata_cleared", i_rdata, '0);
        line_b   = 128'h600DF00D_00000000_00000000_00000020;
        mem_line = line_b;
        mem_lat  = 2;
        i_read   = 1'b1;
        i_addr   = 28'h0000020;
        wait_strobe("rb_fresh");
        chk_a("rb_fresh_addr", mem_addr, 28'h0000020);
        wait_ready("rb_fresh");
        chk_b("rb_fresh_i_ready", i_ready, 1'b1);
        chk_d("rb_fresh_i_rdata", i_rdata, line_b);
        clear_reqs();
        tick();
        tick();

        // Requester input changes while BUSY must not reach memory.
        line_c   = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
        mem_line = line_c;
        mem_lat  = 6;
        d_read   = 1'b1;
        d_addr   = 28'h0000001;
        wait_strobe("ic");
        chk_a("ic_addr_grant", mem_addr, 28'h0000001);
        d_addr = 28'h0000002;
        held = 1'b1;
        for (int n = 0; n < 60 && !d_ready; n++) begin
            if (mem_addr !== 28'h0000001) held = 1'b0;
            tick();
        end
        chk_b("ic_addr_held", held, 1'b1);
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            if (d_ready) pulses++;
            clear_reqs();
            tick();
        end
        chk_b("ic_one_d_ready", pulses == 1, 1'b1);
        chk_d("ic_d_rdata", d_rdata, line_c);

        // Stray mem_ready while IDLE is ignored.
        mem_auto  = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk_b("pe_i_ready", i_ready, 1'b0);
        chk_b("pe_d_ready", d_ready, 1'b0);
        chk_b("pe_strobes", mem_read || mem_write, 1'b0);
        chk_d("pe_i_rdata", i_rdata, line_b);
        chk_d("pe_d_rdata", d_rdata, line_c);
        mem_auto = 1'b1;
        mem_lat  = 1;
        d_write  = 1'b1;
        d_addr   = 28'h0000055;
        d_wdata  = 128'h55;
        tick();
        chk_b("pe_next_grant", mem_write, 1'b1);
        wait_ready("pe_next");
        chk_b("pe_next_d_ready", d_ready, 1'b1);
        clear_reqs();
        tick();
        tick();

        // Randomized traffic against a transaction-level model.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_starve  = 0;
        m_rr_d    = 1'b0;
        m_busy    = 1'b0;
        m_gnt_i   = 1'b0;
        m_ign     = 1'b0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_i_rdata = '0;
        m_d_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (m_busy && mem_ready) begin
                if (m_gnt_i) m_i_rdata = mem_rdata;
                else m_d_rdata = mem_rdata;
                chk_b("rnd_i_ready", i_ready, m_gnt_i);
                chk_b("rnd_d_ready", d_ready, !m_gnt_i);
                chk_b("rnd_strobe_drop", mem_read || mem_write, 1'b0);
                m_busy = 1'b0;
                m_ign  = 1'b1;
                if (m_gnt_i) i_read = 1'b0;
                else begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end else begin
                chk_b("rnd_i_ready_quiet", i_ready, 1'b0);
                chk_b("rnd_d_ready_quiet", d_ready, 1'b0);
                if (m_busy) begin
                    chk_b("rnd_hold_read", mem_read, m_rd);
                    chk_b("rnd_hold_write", mem_write, m_wr);
                    chk_a("rnd_hold_addr", mem_addr, m_addr);
                    chk_d("rnd_hold_wdata", mem_wdata, m_wdata);
                end else if (m_ign) begin
                    chk_b("rnd_done_no_grant", mem_read || mem_write, 1'b0);
                    m_ign = 1'b0;
                end else begin
                    bit req_i;
                    bit req_d;
                    bit win_i;
                    req_i = i_read;
                    req_d = d_read | d_write;
                    chk_b("rnd_grant", mem_read || mem_write, req_i | req_d);
                    if (req_i | req_d) begin
                        if (req_i && req_d) win_i = RR ? !m_rr_d : (m_starve == SL);
                        else win_i = req_i;
                        m_gnt_i = win_i;
                        m_rd    = win_i ? 1'b1 : !d_write;
                        m_wr    = win_i ? 1'b0 : d_write;
                        m_addr  = win_i ? i_addr : d_addr;
                        if (m_wr) m_wdata = d_wdata;
                        else m_wdata = mem_wdata;
                        chk_b("rnd_gnt_read", mem_read, m_rd);
                        chk_b("rnd_gnt_write", mem_write, m_wr);
                        chk_a("rnd_gnt_addr", mem_addr, m_addr);
                        if (m_wr) chk_d("rnd_gnt_wdata", mem_wdata, m_wdata);
                        m_rr_d = !m_rr_d;
                        if (!win_i && req_i) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
                        else m_starve = 0;
                        m_busy = 1'b1;
                    end
                end
            end
            chk_d("rnd_i_rdata", i_rdata, m_i_rdata);
            chk_d("rnd_d_rdata", d_rdata, m_d_rdata);

            mem_line = {$urandom, $urandom, $urandom, $urandom};
            mem_lat  = 1 + int'($urandom_range(0, 3));
            if (m_busy && m_gnt_i) begin
                i_addr = AW'($urandom);
                if ($urandom_range(0, 9) == 0) i_read = 1'b0;
            end else if (!i_read) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_read = 1'b1;
                    i_addr = AW'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                i_read = 1'b0;
            end
            if (m_busy && !m_gnt_i) begin
                d_addr  = AW'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 9) == 0) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end else if (!(d_read || d_write)) begin
                if ($urandom_range(0, 3) == 0) begin
                    int op;
                    op      = int'($urandom_range(0, 2));
                    d_read  = (op != 1);
                    d_write = (op != 0);
                    d_addr  = AW'($urandom);
                    d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end else if ($urandom_range(0, 19) == 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
